fetch_stage: RTL and testbench

- Instruction-fetch stage plus IF/ID pipeline register. It sits directly upstream of the decode control unit.
- Holds the program counter, drives the instruction-memory address, and latches the fetched word into the IF/ID register. That register presents the instruction word to decode.
- Supports hazard stalls and branch flushes. A flush inserts an all-zero instruction word, which decode treats as a NOP.

---
 rtl/fetch_stage.sv | 65 ++++++
 tb/tb_fetch_stage.sv | 109 ++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, instruction-memory address and IF/ID pipeline register.
// A taken branch redirects the PC and flushes IF/ID to an all-zero NOP bubble.
module fetch_stage #(
  parameter int                DATA_W   = 32,
  parameter logic [DATA_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              le_pc,
  input  logic              le_ifid,
  input  logic              branch_taken,
  input  logic [DATA_W-1:0] branch_target,
  output logic [DATA_W-1:0] imem_addr,
  input  logic [DATA_W-1:0] imem_data,
  output logic [DATA_W-1:0] ifid_ir,
  output logic [DATA_W-1:0] ifid_pc4,
  output logic              ifid_valid,
  output logic [7:0]        stall_count
);

  typedef struct packed {
    logic [DATA_W-1:0] ir;
    logic [DATA_W-1:0] pc4;
    logic              valid;
  } ifid_t;

  logic [DATA_W-1:0] pc;
  logic [DATA_W-1:0] pc4;
  logic [DATA_W-1:0] target_aligned;
  ifid_t             ifid;

  // Natural wrap at 2^DATA_W is intended.
  assign pc4            = pc + DATA_W'(4);
  assign target_aligned = {branch_target[DATA_W-1:2], 2'b00};

  always_ff @(posedge clk) begin
    if (reset)             pc <= RESET_PC;
    else if (branch_taken) pc <= target_aligned;
    else if (le_pc)        pc <= pc4;
  end

  // Branch flush beats le_ifid: the word currently in fetch is wrong-path.
  always_ff @(posedge clk) begin
    if (reset || branch_taken) begin
      ifid <= '0;
    end else if (le_ifid) begin
      ifid.ir    <= imem_data;
      ifid.pc4   <= pc4;
      ifid.valid <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset)
      stall_count <= '0;
    else if (!le_pc && !branch_taken && stall_count != 8'hFF)
      stall_count <= stall_count + 8'd1;
  end

  assign imem_addr  = pc;
  assign ifid_ir    = ifid.ir;
  assign ifid_pc4   = ifid.pc4;
  assign ifid_valid = ifid.valid;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage; instruction memory returns address | E000_0000.
module tb_fetch_stage;
  logic        clk = 1'b0;
  logic        reset, le_pc, le_ifid, branch_taken;
  logic [31:0] branch_target, imem_addr, imem_data, ifid_ir, ifid_pc4;
  logic        ifid_valid;
  logic [7:0]  stall_count;
  int          checks = 0, errors = 0;

  always #5 clk = ~clk;

  assign imem_data = imem_addr | 32'hE000_0000;

  fetch_stage #(.DATA_W(32), .RESET_PC(32'h0)) dut (
    .clk(clk), .reset(reset), .le_pc(le_pc), .le_ifid(le_ifid),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .imem_addr(imem_addr), .imem_data(imem_data),
    .ifid_ir(ifid_ir), .ifid_pc4(ifid_pc4), .ifid_valid(ifid_valid),
    .stall_count(stall_count)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  task automatic step(input logic r, input logic lp, input logic li, input logic br,
                      input logic [31:0] tgt);
    reset = r; le_pc = lp; le_ifid = li; branch_taken = br; branch_target = tgt;
    @(posedge clk); #1;
  endtask

  task automatic expect_all(input string tag, input logic [31:0] pc, input logic [31:0] ir,
                            input logic [31:0] p4, input logic v, input logic [7:0] sc);
    chk({tag, ".pc"},    imem_addr, pc);
    chk({tag, ".ir"},    ifid_ir, ir);
    chk({tag, ".pc4"},   ifid_pc4, p4);
    chk({tag, ".valid"}, {31'd0, ifid_valid}, {31'd0, v});
    chk({tag, ".stall"}, {24'd0, stall_count}, {24'd0, sc});
  endtask

  initial begin
    step(1, 1, 1, 0, 0);
    expect_all("reset", 32'h0, 32'h0, 32'h0, 0, 8'd0);

    // Free run
    step(0, 1, 1, 0, 0);
    expect_all("run1", 32'h4, 32'hE000_0000, 32'h4, 1, 8'd0);
    step(0, 1, 1, 0, 0);
    expect_all("run2", 32'h8, 32'hE000_0004, 32'h8, 1, 8'd0);

    // Full stall for 3 cycles at PC=8
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0);
    expect_all("stall3", 32'h8, 32'hE000_0004, 32'h8, 1, 8'd3);
    step(0, 1, 1, 0, 0);
    expect_all("release", 32'hC, 32'hE000_0008, 32'hC, 1, 8'd3);

    // Branch flush with unaligned target
    step(0, 1, 1, 1, 32'h0000_0103);
    expect_all("flush", 32'h100, 32'h0, 32'h0, 0, 8'd3);
    step(0, 1, 1, 0, 0);
    expect_all("target", 32'h104, 32'hE000_0100, 32'h104, 1, 8'd3);

    // Branch while stalled: no stall count
    step(0, 0, 0, 1, 32'h0000_0200);
    expect_all("brstall", 32'h200, 32'h0, 32'h0, 0, 8'd3);

    // PC held but IF/ID loads: same word re-latched
    step(0, 0, 1, 0, 0);
    expect_all("refetch1", 32'h200, 32'hE000_0200, 32'h204, 1, 8'd4);
    step(0, 0, 1, 0, 0);
    expect_all("refetch2", 32'h200, 32'hE000_0200, 32'h204, 1, 8'd5);

    // PC advances but IF/ID holds
    step(0, 1, 0, 0, 0);
    expect_all("drop", 32'h204, 32'hE000_0200, 32'h204, 1, 8'd5);

    // Wrap-around
    step(0, 1, 1, 1, 32'hFFFF_FFFC);
    expect_all("wrapbr", 32'hFFFF_FFFC, 32'h0, 32'h0, 0, 8'd5);
    step(0, 1, 1, 0, 0);
    expect_all("wrap", 32'h0, 32'hFFFF_FFFC, 32'h0, 1, 8'd5);

    // Reset mid-stall (stall_count=5, valid=1), then reset over a branch
    step(0, 1, 1, 1, 32'h40);
    step(0, 1, 1, 0, 0);
    expect_all("pre_rst", 32'h44, 32'hE000_0040, 32'h44, 1, 8'd5);
    step(1, 0, 0, 0, 0);
    expect_all("rst_stall", 32'h0, 32'h0, 32'h0, 0, 8'd0);
    step(1, 1, 1, 1, 32'h300);
    expect_all("rst_branch", 32'h0, 32'h0, 32'h0, 0, 8'd0);

    // Saturation of stall_count
    for (int i = 0; i < 254; i++) step(0, 0, 0, 0, 0);
    expect_all("sat_fe", 32'h0, 32'h0, 32'h0, 0, 8'hFE);
    for (int i = 0; i < 46; i++) step(0, 0, 0, 0, 0);
    expect_all("sat_ff", 32'h0, 32'h0, 32'h0, 0, 8'hFF);

    // Resume from RESET_PC
    step(0, 1, 1, 0, 0);
    expect_all("resume", 32'h4, 32'hE000_0000, 32'h4, 1, 8'hFF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
